mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one variable-latency unified memory port between the 64-bit pipeline's instruction-fetch port and its data port.
- Sits between the core and the memory/cache model. Grants one transaction at a time, data over fetch, with starvation protection for fetch.
- Discards fetch responses aborted by a redirect. Watchdog guards against a memory that never acknowledges.

Parameters:
- N, 64, data/address width of data port and memory port
- IW, 32, instruction width and fetch address width
- STARVE_MAX, 4, consecutive data grants tolerated while a fetch waits
- TIMEOUT, 255, cycles without m_ack before a transaction is abandoned

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
- i_req  in  1  fetch request; held with i_addr until i_hit or i_abort
- i_addr  in  IW  fetch address
- i_abort  in  1  cancel current fetch (branch/jump redirect)
- i_data  out  IW  fetched instruction, valid when i_hit
- i_hit  out  1  one-cycle fetch-done pulse
- d_rd  in  1  data load request
- d_we  in  2  store type: 00 none, 01 32-bit, 10 64-bit, 11 treated as 10
- d_addr  in  N  data address
- d_wdata  in  N  store data
- d_rdata  out  N  load data, valid when d_ready
- d_ready  out  1  one-cycle data-done pulse
- stall  out  1  data request pending and not done (combinational)
- m_req  out  1  memory request
- m_we  out  2  memory write type, 00 = read
- m_addr  out  N  memory address; fetch address zero-extended
- m_wdata  out  N  memory write data
- m_rdata  in  N  memory read data, sampled with m_ack
- m_ack  in  1  memory completion
- err  out  1  sticky timeout flag

Behaviour:
- Reset: state IDLE; m_req=0, m_we=0, m_addr=0, m_wdata=0, i_hit=0, i_data=0, d_ready=0, d_rdata=0, err=0; starvation and watchdog counters 0.
- Data request = d_rd | (d_we!=0). If d_rd and d_we are both set, the write wins and no read data is returned.
- States: IDLE, IFETCH, DACC, IDROP.
- IDLE arbitration:
  - Data request and starve count < STARVE_MAX → DACC.
  - Else i_req & ~i_abort → IFETCH.
  - i_req with starve count == STARVE_MAX → IFETCH even if data is pending.
- Starve count:
  - Increments on each DACC grant while i_req is high.
  - Clears on an IFETCH grant or when i_req is low.
  - Saturates at STARVE_MAX.
- On grant, m_req, m_addr, m_we and m_wdata are registered. They are stable from the next cycle until the ack cycle.
- Completion occurs in the cycle m_ack=1 while m_req=1. Next cycle m_req=0, state IDLE, and i_hit or d_ready pulses with the captured data.
- Minimum latency: request cycle → response pulse is 3 cycles (grant, ack, pulse). Back-to-back grants are allowed from IDLE in the pulse cycle.
- m_ack while m_req=0 is ignored.
- i_abort in IFETCH before ack → IDROP. The memory transaction runs to its ack, data is discarded, and no i_hit is produced.
- i_abort in the ack cycle also suppresses i_hit.
- i_abort in IDLE blocks a fetch grant that cycle.
- Data transactions are never cancelled.
- stall = data request & ~d_ready; it is high in the cycle the request is presented, even when granted.
- Watchdog:
  - Counts each cycle m_req=1 without m_ack.
  - At TIMEOUT: drop m_req, set err, return to IDLE, and pulse d_ready/i_hit with zero data (the i_hit pulse is suppressed if aborted).
  - Counter clears on every grant.
- Reset mid-transaction: back to IDLE in one cycle, m_req=0 the next cycle. A late m_ack is ignored; err is cleared.

Test Plan:
- Fetch only: i_req=1, i_addr=0x40; memory acks 2 cycles after m_req with 0x8C010004 → m_addr=0x40, m_we=00, single i_hit with i_data=0x8C010004.
- Simultaneous: i_req and d_we=10, d_addr=0x100, d_wdata=0xDEADBEEF00000001 in the same cycle → data granted first (m_we=10, stall high until d_ready), fetch granted the cycle d_ready pulses.
- Starvation: d_rd held high for 10 requests while i_req waits, STARVE_MAX=4 → exactly 4 data grants, then one fetch grant, then data resumes.
- Abort: fetch granted, i_abort pulsed before m_ack, ack after 3 cycles → no i_hit, m_req held until ack, next fetch of new address starts after return to IDLE.
- Timeout: TIMEOUT=8, memory never acks a d_rd → m_req drops after 8 cycles, err=1, d_ready pulses with d_rdata=0; err stays 1 until reset=0.
- Reset mid-op: reset=0 during DACC, m_ack arrives 1 cycle later → all outputs at reset values, no d_ready, late ack ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory port between the instruction-fetch
// port and the data port. One transaction at a time, data preferred over fetch,
// with a starvation counter so a waiting fetch is eventually served. Fetches
// redirected mid-flight run to completion on the memory side but are discarded.
// A watchdog abandons any transaction the memory never acknowledges.
//
// Handshake summary (all ports):
//   i_req/i_addr are held by the core until it sees i_hit or raises i_abort;
//   d_rd/d_we/d_addr/d_wdata are held until d_ready. The core may present its
//   next request in the same cycle a done pulse is high, and that request is
//   eligible for a grant in that cycle. On the memory side m_req is a level:
//   m_addr/m_we/m_wdata are stable while m_req=1, and the transaction completes
//   in the cycle m_ack=1 with m_req=1. m_ack while m_req=0 is ignored.
module mem_port_arbiter #(
  parameter int N          = 64,
  parameter int IW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [IW-1:0] i_addr,
  input  logic          i_abort,
  output logic [IW-1:0] i_data,
  output logic          i_hit,
  input  logic          d_rd,
  input  logic [1:0]    d_we,
  input  logic [N-1:0]  d_addr,
  input  logic [N-1:0]  d_wdata,
  output logic [N-1:0]  d_rdata,
  output logic          d_ready,
  output logic          stall,
  output logic          m_req,
  output logic [1:0]    m_we,
  output logic [N-1:0]  m_addr,
  output logic [N-1:0]  m_wdata,
  input  logic [N-1:0]  m_rdata,
  input  logic          m_ack,
  output logic          err
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DACC   = 2'd2,
    IDROP  = 2'd3
  } state_t;

  // Current FSM state; kept as a named enum so checkers can bind to it.
  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wd_cnt;

  logic       data_req;
  logic [1:0] we_eff;
  logic       starved;
  logic       data_grant;
  logic       fetch_grant;
  logic       wd_expired;

  // Request decode and IDLE arbitration; a write beats a simultaneous read.
  always_comb begin
    data_req    = d_rd | (d_we != 2'b00);
    we_eff      = (d_we == 2'b11) ? 2'b10 : d_we;
    starved     = (starve_cnt == SW'(STARVE_MAX));
    data_grant  = data_req & ~starved;
    fetch_grant = ~data_grant & i_req & ~i_abort;
    wd_expired  = (wd_cnt == WW'(TIMEOUT - 1));
  end

  assign stall = data_req & ~d_ready;

  // Arbitration FSM with registered memory-side and core-side outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wd_cnt     <= '0;
      m_req      <= 1'b0;
      m_we       <= 2'b00;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_hit      <= 1'b0;
      i_data     <= '0;
      d_ready    <= 1'b0;
      d_rdata    <= '0;
      err        <= 1'b0;
    end else begin
      i_hit   <= 1'b0;
      d_ready <= 1'b0;
      if (!i_req) starve_cnt <= '0;
      case (state)
        IDLE: begin
          if (data_grant) begin
            state   <= DACC;
            m_req   <= 1'b1;
            m_addr  <= d_addr;
            m_we    <= we_eff;
            m_wdata <= d_wdata;
            wd_cnt  <= '0;
            // data_grant already guarantees the count is below its ceiling
            if (i_req) starve_cnt <= starve_cnt + 1'b1;
          end else if (fetch_grant) begin
            state      <= IFETCH;
            m_req      <= 1'b1;
            m_addr     <= {{(N - IW){1'b0}}, i_addr};
            m_we       <= 2'b00;
            m_wdata    <= '0;
            wd_cnt     <= '0;
            starve_cnt <= '0;
          end
        end
        default: begin
          if (m_ack) begin
            m_req <= 1'b0;
            state <= IDLE;
            if (state == IFETCH && !i_abort) begin
              i_hit  <= 1'b1;
              i_data <= m_rdata[IW-1:0];
            end
            if (state == DACC) begin
              d_ready <= 1'b1;
              d_rdata <= (m_we == 2'b00) ? m_rdata : '0;
            end
          end else if (wd_expired) begin
            m_req <= 1'b0;
            state <= IDLE;
            err   <= 1'b1;
            if (state == IFETCH && !i_abort) begin
              i_hit  <= 1'b1;
              i_data <= '0;
            end
            if (state == DACC) begin
              d_ready <= 1'b1;
              d_rdata <= '0;
            end
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (state == IFETCH && i_abort) state <= IDROP;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter (STARVE_MAX=4, TIMEOUT=8).
module tb_mem_port_arbiter;

  localparam int N  = 64;
  localparam int IW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          i_req = 1'b0, i_abort = 1'b0;
  logic [IW-1:0] i_addr = '0;
  logic [IW-1:0] i_data;
  logic          i_hit;
  logic          d_rd = 1'b0;
  logic [1:0]    d_we = 2'b00;
  logic [N-1:0]  d_addr = '0, d_wdata = '0;
  logic [N-1:0]  d_rdata;
  logic          d_ready, stall;
  logic          m_req;
  logic [1:0]    m_we;
  logic [N-1:0]  m_addr, m_wdata;
  logic [N-1:0]  m_rdata;
  logic          m_ack;
  logic          err;

  // memory model: manual ack/data, or auto-ack every request with address-derived data
  logic         auto_mem = 1'b0;
  logic         man_ack = 1'b0;
  logic [N-1:0] man_rdata = '0;
  assign m_ack   = auto_mem ? m_req : man_ack;
  assign m_rdata = auto_mem ? {32'hA5A5_0000, m_addr[31:0]} : man_rdata;

  mem_port_arbiter #(.N(N), .IW(IW), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort), .i_data(i_data), .i_hit(i_hit),
    .d_rd(d_rd), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .stall(stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .err(err)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int hit_cnt = 0;
  int rdy_cnt = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_q[$];
  logic m_req_prev = 1'b0;

  // monitor: count done pulses and log the address of every new grant
  always @(negedge clk) begin
    if (i_hit) hit_cnt++;
    if (d_ready) rdy_cnt++;
    if (m_req && !m_req_prev) got_q.push_back(m_addr);
    m_req_prev = m_req;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0;
    tick; tick;
    n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL rst_m_req: got %b want 0", m_req); end
    n_cmp++; if (m_we !== 2'b00) begin n_bad++; $display("FAIL rst_m_we: got %b want 00", m_we); end
    n_cmp++; if (m_addr !== 64'h0) begin n_bad++; $display("FAIL rst_m_addr: got %h want 0", m_addr); end
    n_cmp++; if (m_wdata !== 64'h0) begin n_bad++; $display("FAIL rst_m_wdata: got %h want 0", m_wdata); end
    n_cmp++; if (i_hit !== 1'b0) begin n_bad++; $display("FAIL rst_i_hit: got %b want 0", i_hit); end
    n_cmp++; if (i_data !== 32'h0) begin n_bad++; $display("FAIL rst_i_data: got %h want 0", i_data); end
    n_cmp++; if (d_ready !== 1'b0) begin n_bad++; $display("FAIL rst_d_ready: got %b want 0", d_ready); end
    n_cmp++; if (d_rdata !== 64'h0) begin n_bad++; $display("FAIL rst_d_rdata: got %h want 0", d_rdata); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    reset = 1'b1;
    tick;
    n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL idle_m_req: got %b want 0", m_req); end
  endtask

  task automatic test_fetch;
    int h0;
    h0 = hit_cnt;
    i_req = 1'b1; i_addr = 32'h40;
    tick;
    n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("FAIL f_m_req: got %b want 1", m_req); end
    n_cmp++; if (m_addr !== 64'h40) begin n_bad++; $display("FAIL f_m_addr: got %h want 40", m_addr); end
    n_cmp++; if (m_we !== 2'b00) begin n_bad++; $display("FAIL f_m_we: got %b want 00", m_we); end
    tick;
    n_cmp++; if (m_req !== 1'b1 || i_hit !== 1'b0) begin n_bad++; $display("FAIL f_wait: got m_req=%b i_hit=%b want 1 0", m_req, i_hit); end
    tick;
    man_ack = 1'b1; man_rdata = 64'h0000_0000_8C01_0004;
    tick;
    man_ack = 1'b0;
    n_cmp++; if (i_hit !== 1'b1) begin n_bad++; $display("FAIL f_i_hit: got %b want 1", i_hit); end
    n_cmp++; if (i_data !== 32'h8C01_0004) begin n_bad++; $display("FAIL f_i_data: got %h want 8c010004", i_data); end
    n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL f_m_req_done: got %b want 0", m_req); end
    i_req = 1'b0;
    tick;
    n_cmp++; if (i_hit !== 1'b0 || m_req !== 1'b0) begin n_bad++; $display("FAIL f_after: got i_hit=%b m_req=%b want 0 0", i_hit, m_req); end
    n_cmp++; if (hit_cnt - h0 !== 1) begin n_bad++; $display("FAIL f_hit_count: got %0d want 1", hit_cnt - h0); end
  endtask

  task automatic test_simultaneous;
    i_req = 1'b1; i_addr = 32'h80;
    d_we = 2'b10; d_addr = 64'h100; d_wdata = 64'hDEAD_BEEF_0000_0001;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL s_stall_req: got %b want 1", stall); end
    tick;
    n_cmp++; if (m_req !== 1'b1 || m_we !== 2'b10) begin n_bad++; $display("FAIL s_grant: got m_req=%b m_we=%b want 1 10", m_req, m_we); end
    n_cmp++; if (m_addr !== 64'h100) begin n_bad++; $display("FAIL s_m_addr: got %h want 100", m_addr); end
    n_cmp++; if (m_wdata !== 64'hDEAD_BEEF_0000_0001) begin n_bad++; $display("FAIL s_m_wdata: got %h want deadbeef00000001", m_wdata); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL s_stall_busy: got %b want 1", stall); end
    man_ack = 1'b1;
    tick;
    man_ack = 1'b0;
    n_cmp++; if (d_ready !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL s_done: got d_ready=%b stall=%b want 1 0", d_ready, stall); end
    n_cmp++; if (d_rdata !== 64'h0) begin n_bad++; $display("FAIL s_wr_rdata: got %h want 0", d_rdata); end
    d_we = 2'b00;
    tick;
    n_cmp++; if (m_req !== 1'b1 || m_addr !== 64'h80 || m_we !== 2'b00) begin n_bad++; $display("FAIL s_fetch_grant: got m_req=%b m_addr=%h m_we=%b want 1 80 00", m_req, m_addr, m_we); end
    man_ack = 1'b1; man_rdata = 64'h1234_5678;
    tick;
    man_ack = 1'b0;
    n_cmp++; if (i_hit !== 1'b1 || i_data !== 32'h1234_5678) begin n_bad++; $display("FAIL s_fetch_done: got i_hit=%b i_data=%h want 1 12345678", i_hit, i_data); end
    i_req = 1'b0;
    tick;
  endtask

  task automatic test_starvation;
    int dcnt;
    int h0;
    h0 = hit_cnt;
    got_q.delete();
    exp_q = '{64'h1000, 64'h1008, 64'h1010, 64'h1018, 64'h200,
              64'h1020, 64'h1028, 64'h1030, 64'h1038, 64'h1040, 64'h1048};
    auto_mem = 1'b1;
    dcnt = 0;
    i_req = 1'b1; i_addr = 32'h200;
    d_rd = 1'b1; d_addr = 64'h1000;
    for (int c = 0; c < 300 && (d_rd || i_req); c++) begin
      tick;
      if (d_ready) begin
        dcnt++;
        if (dcnt == 10) d_rd = 1'b0;
        else d_addr = 64'h1000 + 64'(dcnt * 8);
      end
      if (i_hit) begin
        n_cmp++; if (i_data !== 32'h200) begin n_bad++; $display("FAIL st_i_data: got %h want 200", i_data); end
        i_req = 1'b0;
      end
    end
    n_cmp++; if (d_rd || i_req) begin n_bad++; $display("FAIL st_timeout: got d_rd=%b i_req=%b want 0 0", d_rd, i_req); end
    d_rd = 1'b0; i_req = 1'b0;
    tick;
    auto_mem = 1'b0;
    n_cmp++; if (got_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL st_grants: got %0d want %0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_cmp++; if (got_q[k] !== exp_q[k]) begin n_bad++; $display("FAIL st_grant_%0d: got %h want %h", k, got_q[k], exp_q[k]); end
    end
    n_cmp++; if (hit_cnt - h0 !== 1) begin n_bad++; $display("FAIL st_hits: got %0d want 1", hit_cnt - h0); end
  endtask

  task automatic test_abort;
    int h0;
    h0 = hit_cnt;
    i_req = 1'b1; i_addr = 32'h300;
    tick;
    n_cmp++; if (m_req !== 1'b1 || m_addr !== 64'h300) begin n_bad++; $display("FAIL a_grant: got m_req=%b m_addr=%h want 1 300", m_req, m_addr); end
    i_abort = 1'b1;
    tick;
    i_abort = 1'b0; i_addr = 32'h400;
    n_cmp++; if (m_req !== 1'b1) begin n_bad++; $display("FAIL a_hold1: got %b want 1", m_req); end
    tick;
    n_cmp++; if (m_req !== 1'b1 || m_addr !== 64'h300) begin n_bad++; $display("FAIL a_hold2: got m_req=%b m_addr=%h want 1 300", m_req, m_addr); end
    man_ack = 1'b1; man_rdata = 64'hBAD;
    tick;
    man_ack = 1'b0;
    n_cmp++; if (i_hit !== 1'b0 || m_req !== 1'b0) begin n_bad++; $display("FAIL a_drop: got i_hit=%b m_req=%b want 0 0", i_hit, m_req); end
    tick;
    n_cmp++; if (m_req !== 1'b1 || m_addr !== 64'h400) begin n_bad++; $display("FAIL a_refetch: got m_req=%b m_addr=%h want 1 400", m_req, m_addr); end
    man_ack = 1'b1; man_rdata = 64'h600D;
    tick;
    man_ack = 1'b0;
    n_cmp++; if (i_hit !== 1'b1 || i_data !== 32'h600D) begin n_bad++; $display("FAIL a_refetch_done: got i_hit=%b i_data=%h want 1 600d", i_hit, i_data); end
    i_req = 1'b0;
    tick;
    n_cmp++; if (hit_cnt - h0 !== 1) begin n_bad++; $display("FAIL a_hits: got %0d want 1", hit_cnt - h0); end
  endtask

  task automatic test_abort_edges;
    int h0;
    h0 = hit_cnt;
    // abort in IDLE blocks the fetch grant
    i_req = 1'b1; i_abort = 1'b1; i_addr = 32'h480;
    tick;
    n_cmp++; if (m_req !== 1'b0) begin n_bad++; $display("FAIL ae_idle_block: got %b want 0", m_req); end
    i_abort = 1'b0; i_addr = 32'h500;
    tick;
    n_cmp++; if (m_req !== 1'b1 || m_addr !== 64'h500) begin n_bad++; $display("FAIL ae_grant: got m_req=%b m_addr=%h want 1 500", m_req, m_addr); end
    // abort coinciding with the ack
    man_ack = 1'b1; man_rdata = 64'h5555; i_abort = 1'b1;
    tick;
    man_ack = 1'b0; i_abort = 1'b0; i_req = 1'b0;
    n_cmp++; if (i_hit !== 1'b0 || m_req !== 1'b0) begin n_bad++; $display("FAIL ae_ack_abort: got i_hit=%b m_req=%b want 0 0", i_hit, m_req); end
    tick;
    n_cmp++; if (hit_cnt - h0 !== 0) begin n_bad++; $display("FAIL ae_hits: got %0d want 0", hit_cnt - h0); end
  endtask

  task automatic test_timeout;
    int r0;
    r0 = rdy_cnt;
    d_rd = 1'b1; d_addr = 64'h700;
    man_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (m_req !== 1'b1 || err !== 1'b0 || stall !== 1'b1) begin n_bad++; $display("FAIL to_wait_%0d: got m_req=%b err=%b stall=%b want 1 0 1", k, m_req, err, stall); end
      tick;
    end
    n_cmp++; if (m_req !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL to_expire: got m_req=%b err=%b want 0 1", m_req, err); end
    n_cmp++; if (d_ready !== 1'b1 || d_rdata !== 64'h0) begin n_bad++; $display("FAIL to_pulse: got d_ready=%b d_rdata=%h want 1 0", d_ready, d_rdata); end
    d_rd = 1'b0;
    tick; tick; tick;
    n_cmp++; if (err !== 1'b1 || d_ready !== 1'b0) begin n_bad++; $display("FAIL to_sticky: got err=%b d_ready=%b want 1 0", err, d_ready); end
    n_cmp++; if (rdy_cnt - r0 !== 1) begin n_bad++; $display("FAIL to_pulses: got %0d want 1", rdy_cnt - r0); end
  endtask

  task automatic test_reset_midop;
    int r0;
    d_rd = 1'b1; d_addr = 64'h800;
    tick;
    r0 = rdy_cnt;
    n_cmp++; if (m_req !== 1'b1 || m_addr !== 64'h800) begin n_bad++; $display("FAIL rm_grant: got m_req=%b m_addr=%h want 1 800", m_req, m_addr); end
    reset = 1'b0; d_rd = 1'b0;
    tick;
    n_cmp++; if (m_req !== 1'b0 || err !== 1'b0 || m_addr !== 64'h0) begin n_bad++; $display("FAIL rm_reset: got m_req=%b err=%b m_addr=%h want 0 0 0", m_req, err, m_addr); end
    reset = 1'b1; man_ack = 1'b1; man_rdata = 64'h77;
    tick;
    man_ack = 1'b0;
    n_cmp++; if (d_ready !== 1'b0 || m_req !== 1'b0 || d_rdata !== 64'h0) begin n_bad++; $display("FAIL rm_late_ack: got d_ready=%b m_req=%b d_rdata=%h want 0 0 0", d_ready, m_req, d_rdata); end
    tick;
    n_cmp++; if (rdy_cnt - r0 !== 0) begin n_bad++; $display("FAIL rm_pulses: got %0d want 0", rdy_cnt - r0); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset;
    test_fetch;
    test_simultaneous;
    test_starvation;
    test_abort;
    test_abort_edges;
    test_timeout;
    test_reset_midop;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
